// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: func codes, FSM states, grant id.
package alu_pkg;

  localparam logic [2:0] F_ADD  = 3'b000;
  localparam logic [2:0] F_SLL  = 3'b001;
  localparam logic [2:0] F_SLT  = 3'b010;
  localparam logic [2:0] F_SLTU = 3'b011;
  localparam logic [2:0] F_XOR  = 3'b100;
  localparam logic [2:0] F_SRL  = 3'b101;
  localparam logic [2:0] F_OR   = 3'b110;
  localparam logic [2:0] F_AND  = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef logic grant_t;

  // Shifts and compares are reserved codes the alu does not implement yet.
  function automatic logic func_supported(input logic [2:0] f);
    return (f == F_ADD) || (f == F_XOR) || (f == F_OR) || (f == F_AND);
  endfunction

endpackage

// File: rtl/alu_rr_picker.sv
// Two-way request picker: round-robin on ties, or fixed priority to
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_rr_picker
  import alu_pkg::*;
(
  input  logic [1:0] req_valid,
  input  grant_t     last_grant,
  output logic       grant_valid,
  output grant_t     grant_id
);

  assign grant_valid = |req_valid;

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign grant_id          = ~req_valid[0];
`else
  always_comb begin
    grant_id = req_valid[1];
    if (&req_valid) grant_id = ~last_grant;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two requesters over valid/ready.
// Optional ALU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [5:0]        req_func,
  input  logic [1:0]        req_sign,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err,
  output logic [2:0]        alu_func,
  output logic              alu_sign,
  output logic [XLEN-1:0]   alu_op_a,
  output logic [XLEN-1:0]   alu_op_b,
  input  logic [XLEN-1:0]   alu_res
);

  state_t            state_q;
  grant_t            grant_q;
  grant_t            last_grant_q;
  logic [2:0]        func_q;
  logic              sign_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   rsp_data_q;
  logic              rsp_err_q;
  logic [1:0]        rsp_valid_q;

  logic              grant_valid;
  grant_t            grant_id;
  logic              accept;

  alu_rr_picker u_picker (
    .req_valid   (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Gated by rst so nothing is accepted in the reset cycle itself.
  assign accept = (state_q == IDLE) && grant_valid && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= grant_t'(1'b0);
      last_grant_q <= grant_t'(1'b1);
      func_q       <= '0;
      sign_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            grant_q      <= grant_id;
            last_grant_q <= grant_id;
            func_q       <= grant_id ? req_func[5:3]        : req_func[2:0];
            sign_q       <= grant_id ? req_sign[1]          : req_sign[0];
            a_q          <= grant_id ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
            b_q          <= grant_id ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_err_q            <= !func_supported(func_q);
          rsp_data_q           <= func_supported(func_q) ? alu_res : '0;
          rsp_valid_q[grant_q] <= 1'b1;
          state_q              <= RESP;
        end
        RESP: begin
          if (rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign alu_func  = func_q;
  assign alu_sign  = sign_q;
  assign alu_op_a  = a_q;
  assign alu_op_b  = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed cases plus randomized
// transactions against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int unsigned XLEN = 64;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [5:0]        req_func;
  logic [1:0]        req_sign;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [XLEN-1:0]   rsp_data;
  logic              rsp_err;
  logic [2:0]        alu_func;
  logic              alu_sign;
  logic [XLEN-1:0]   alu_op_a;
  logic [XLEN-1:0]   alu_op_b;
  logic [XLEN-1:0]   alu_res;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        last_g;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_sign  (req_sign),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_func  (alu_func),
    .alu_sign  (alu_sign),
    .alu_op_a  (alu_op_a),
    .alu_op_b  (alu_op_b),
    .alu_res   (alu_res)
  );

  // Stand-in alu; unimplemented codes return junk that the arbiter must zero.
  always_comb begin
    alu_res = 64'hA5A5_5A5A_DEAD_BEEF;
    case (alu_func)
      3'b000:  alu_res = alu_sign ? alu_op_a - alu_op_b : alu_op_a + alu_op_b;
      3'b100:  alu_res = alu_op_a ^ alu_op_b;
      3'b110:  alu_res = alu_op_a | alu_op_b;
      3'b111:  alu_res = alu_op_a & alu_op_b;
      default: alu_res = 64'hA5A5_5A5A_DEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [2:0] f, input logic s, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] r, output logic e);
    e = 1'b0;
    case (f)
      3'b000:  r = s ? a - b : a + b;
      3'b100:  r = a ^ b;
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; rsp_ready = '0;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_alu_a", alu_op_a, 64'd0);
    chk("rst_alu_b", alu_op_b, 64'd0);
    chk("rst_alu_fs", 64'({alu_func, alu_sign}), 64'd0);
    last_g = 1'b1;
  endtask

  // One complete op; entered and left one time unit after a rising edge.
  task automatic transact(input logic [1:0] v, input logic [5:0] f, input logic [1:0] s,
                          input logic [63:0] a0, input logic [63:0] a1,
                          input logic [63:0] b0, input logic [63:0] b1, input int unsigned stall);
    logic        win;
    logic [2:0]  fw;
    logic [63:0] aw, bw, er;
    logic        ee;
    logic [1:0]  oh;
    req_valid = v; req_func = f; req_sign = s;
    req_a = {a1, a0}; req_b = {b1, b0}; rsp_ready = '0;
    if (v == 2'b11) win = FIXED ? 1'b0 : ~last_g;
    else            win = v[1];
    oh = win ? 2'b10 : 2'b01;
    fw = win ? f[5:3] : f[2:0];
    aw = win ? a1 : a0;
    bw = win ? b1 : b0;
    ref_op(fw, s[win], aw, bw, er, ee);
    @(negedge clk);
    chk("accept_ready", 64'(req_ready), 64'(oh));
    @(posedge clk); #1;
    chk("exec_ready", 64'(req_ready), 64'd0);
    chk("exec_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_alu_a", alu_op_a, aw);
    chk("exec_alu_b", alu_op_b, bw);
    chk("exec_alu_fs", 64'({alu_func, alu_sign}), 64'({fw, s[win]}));
    @(posedge clk); #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("rsp_data", rsp_data, er);
    chk("rsp_err", 64'(rsp_err), 64'(ee));
    for (int unsigned i = 0; i < stall; i++) begin
      rsp_ready = ~oh;
      @(posedge clk); #1;
      chk("stall_valid", 64'(rsp_valid), 64'(oh));
      chk("stall_data", rsp_data, er);
      chk("stall_err", 64'(rsp_err), 64'(ee));
      chk("stall_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("post_hs_valid", 64'(rsp_valid), 64'd0);
    last_g = win;
  endtask

  initial begin
    req_valid = '0; req_func = '0; req_sign = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    rst = 1'b1;
    do_reset();

    transact(2'b01, 6'o00, 2'b00, 64'd5, 64'd0, 64'd7, 64'd0, 0);
    transact(2'b10, 6'o00, 2'b10, 64'd0, 64'd3, 64'd0, 64'd5, 0);
    for (int unsigned k = 0; k < 4; k++)
      transact(2'b11, 6'o64, 2'b00, 64'hF0F0_1234_0000_FFFF + 64'(k), 64'h0F0F_0000_AAAA_5555,
               64'h00FF_00FF_00FF_00FF, 64'h1111_2222_3333_4444 + 64'(k), 0);
    transact(2'b01, 6'o04, 2'b00, 64'hDEAD_0000_0000_0001, 64'd0, 64'h1234, 64'd0, 4);
    transact(2'b01, 6'o01, 2'b00, 64'd1, 64'd0, 64'd1, 64'd0, 0);

    // Abort an op in EXEC with reset, then verify port 0 still works.
    req_valid = 2'b01; req_func = 6'o00; req_sign = '0; req_a = {64'd0, 64'd9}; req_b = {64'd0, 64'd9};
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("abort_rsp_data", rsp_data, 64'd0);
    chk("abort_alu_a", alu_op_a, 64'd0);
    last_g = 1'b1;
    @(posedge clk); #1;
    chk("abort_quiet", 64'(rsp_valid), 64'd0);
    transact(2'b01, 6'o00, 2'b00, 64'd100, 64'd0, 64'd23, 64'd0, 0);

    for (int unsigned k = 0; k < 40; k++) begin
      transact(2'($urandom_range(1, 3)), 6'($urandom), 2'($urandom),
               {$urandom, $urandom}, {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
    end
    req_valid = '0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational alu (func/sign/op_a/op_b -> res) between two requesters, e.g. the execute stage (port 0) and the branch/address-generation unit (port 1).
- Accepts requests over valid/ready, registers the operands and drives the alu from registers.
- Captures the result and returns it to the granting requester over a per-port valid/ready response channel.
- Flags func codes the alu does not implement.

Parameters:
- XLEN, 64, operand/result width; must match the alu.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester request accepted this cycle.
- req_func  in  6  funct3 per requester; bits [3i+2:3i].
- req_sign  in  2  funct7[5] per requester (SUB when func=ADD).
- req_a  in  2*XLEN  operand A per requester; slice [XLEN*i +: XLEN].
- req_b  in  2*XLEN  operand B per requester.
- rsp_valid  out  2  response valid to requester i.
- rsp_ready  in  2  requester i accepts the response.
- rsp_data  out  XLEN  result; shared bus, meaningful only where rsp_valid is set.
- rsp_err  out  1  unsupported func; qualified by rsp_valid.
- alu_func  out  3  to alu func.
- alu_sign  out  1  to alu sign.
- alu_op_a  out  XLEN  to alu op_a.
- alu_op_b  out  XLEN  to alu op_b.
- alu_res  in  XLEN  from alu res.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset enters IDLE.
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Operand registers 0, alu_* outputs 0.
  - grant register 0, last_grant=1, so requester 0 wins the first tie.
- IDLE:
  - req_ready[i] is combinational: set only for the winning requester i with req_valid[i]=1. Never set in EXEC or RESP.
  - Winner: if one valid, that one. If both valid, the requester != last_grant (round-robin).
  - On acceptance (cycle N), latch func/sign/a/b and the grant id, update last_grant, go to EXEC.
- EXEC (cycle N+1):
  - alu_* outputs driven from the operand registers; they are stable across the whole state.
  - At the end of the cycle, capture alu_res into rsp_data.
  - rsp_err=1 if func is not in {000 ADD/SUB, 100 XOR, 110 OR, 111 AND}; rsp_data is then 0.
  - Go to RESP.
- RESP (cycle N+2 onward):
  - rsp_valid[grant]=1; the other bit stays 0. rsp_data/rsp_err held stable until the handshake.
  - On rsp_ready[grant]=1, go to IDLE next cycle.
  - rsp_ready on the non-granted port is ignored.
- Latency and throughput:
  - Accept-to-rsp_valid is 2 cycles.
  - Peak throughput is 1 op per 3 cycles; a new accept is possible the cycle after the response handshake.
- Requests held while waiting must keep their payload stable; the losing requester is served on the next IDLE if still valid.
- Arithmetic is XLEN-bit wrap-around (ADD/SUB modulo 2^XLEN); no overflow flag.
- A synchronous reset in any state aborts the in-flight op: no response is issued and the FSM is in IDLE the next cycle.
- alu_* outputs are never X after reset: the operand registers are reset.

Optional Feature:
- ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are valid; last_grant is unused and round-robin is disabled.
- Undefined: round-robin as described above.

Decomposition:
- Shared package alu_pkg holds:
  - func constants F_ADD=3'b000, F_XOR=3'b100, F_OR=3'b110, F_AND=3'b111, plus the pending F_SLL/F_SLT/F_SLTU/F_SRL.
  - FSM state typedef {IDLE, EXEC, RESP}.
  - Grant-id typedef (1 bit).
- One sub-module: alu_rr_picker.
  - Inputs: req_valid[1:0], last_grant.
  - Outputs: grant_valid, grant_id.
  - Contains the fixed-priority override under the macro.

Test Plan:
1. Port 0 only: func=000, sign=0, a=5, b=7 -> req_ready[0] same cycle; rsp_valid[0] 2 cycles later; rsp_data=12, rsp_err=0.
2. Port 1: func=000, sign=1, a=3, b=5 -> rsp_data=64'hFFFF_FFFF_FFFF_FFFE (wrap), rsp_valid[1] only.
3. Both ports valid continuously, port0 a^b (XOR), port1 a|b (OR) -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN, port 0 always wins.
4. Response backpressure: rsp_ready[0]=0 for 4 cycles -> rsp_valid[0], rsp_data, rsp_err stable; req_ready=0 for both ports throughout; accept is possible on the cycle after rsp_ready.
5. Unsupported func=001, a=1, b=1 -> rsp_err=1, rsp_data=0.
6. rst asserted during EXEC -> no rsp_valid; all outputs at reset values next cycle; the next request from port 0 completes normally.
